// File: rtl/dsp_pkg.sv
// Shared definitions for the audio output path: sample width, stream FSM
// state encodings and the saturated-magnitude helper used by peak tracking.
// No ports; imported by audio_bank and audio_out_bank.
package dsp_pkg;

  localparam int AUDIO_W = 16;

  // Magnitude of the most negative sample cannot be represented, so it is
  // clamped to the largest positive value.
  localparam logic [AUDIO_W-1:0] PEAK_SAT = 16'h7FFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic logic [AUDIO_W-1:0] abs_sat(input logic [AUDIO_W-1:0] x);
    if (x == {1'b1, {(AUDIO_W-1){1'b0}}}) begin
      return PEAK_SAT;
    end else if (x[AUDIO_W-1]) begin
      return ~x + 1'b1;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/audio_bank.sv
// One channel bank: 2**CHAN_W x 16-bit sample store plus a per-channel written-mask.
// Latency: 1-cycle write; read is combinational, unwritten channels read as zero.
// Backpressure: none; writes are always accepted.
// Ports: ck/rst clock and async active-low reset; clr clears the written-mask;
//        we/waddr/wdata write port; raddr/rdata masked read port.
module audio_bank
  import dsp_pkg::*;
#(
  parameter int CHAN_W = 4
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [CHAN_W-1:0]  waddr,
  input  logic [AUDIO_W-1:0] wdata,
  input  logic [CHAN_W-1:0]  raddr,
  output logic [AUDIO_W-1:0] rdata
);

  localparam int DEPTH = 2**CHAN_W;

  logic [AUDIO_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   written;

  // Sample storage carries no reset; the written-mask makes stale contents invisible.
  always_ff @(posedge ck) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      written <= '0;
    end else begin
      if (clr) begin
        written <= '0;
      end
      if (we) begin
        written[waddr] <= 1'b1;
      end
    end
  end

  assign rdata = written[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/audio_out_bank.sv
// Double-buffered capture of sequencer channel writes; on each 'done' rising edge the
// completed bank is streamed channel 0..OUT_CHANS-1. Latency: first beat 1 cycle after swap.
// Backpressure: tx_ready low holds the current beat stable; frames completing mid-stream are dropped (overrun).
// Ports: ck, rst (async active-low); in_we/in_addr/in_audio sample writes; done frame-complete level;
//        tx_valid/tx_ready/tx_chan/tx_data/tx_last output stream; overrun sticky flag; frames counter.
// Optional: define AUDIO_OUT_PEAK_EN to add peak_sel/peak_clr/peak per-channel peak magnitude tracking.
module audio_out_bank
  import dsp_pkg::*;
#(
  parameter int CHAN_W    = 4,
  parameter int OUT_CHANS = 8
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               in_we,
  input  logic [CHAN_W-1:0]  in_addr,
  input  logic [AUDIO_W-1:0] in_audio,
  input  logic               done,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [CHAN_W-1:0]  tx_chan,
  output logic [AUDIO_W-1:0] tx_data,
  output logic               tx_last,
  output logic               overrun,
  output logic [15:0]        frames
`ifdef AUDIO_OUT_PEAK_EN
  ,
  input  logic [CHAN_W-1:0]  peak_sel,
  input  logic               peak_clr,
  output logic [AUDIO_W-1:0] peak
`endif
);

  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(OUT_CHANS - 1);

  state_t             state;
  logic               done_d;
  logic               wsel;      // bank currently accumulating writes; ~wsel is the read bank
  logic               swap;
  logic               swap_acc;
  logic [CHAN_W-1:0]  rd_addr;
  logic               rd_bank;
  logic [AUDIO_W-1:0] rdata0;
  logic [AUDIO_W-1:0] rdata1;
  logic [AUDIO_W-1:0] rd_data;
  logic [AUDIO_W-1:0] first_data;

  assign swap     = done & ~done_d;
  assign swap_acc = swap & (state == ST_IDLE);

  // The beat registered next cycle is read ahead: channel 0 of the retiring write
  // bank at a swap, otherwise the following channel of the read bank.
  always_comb begin
    rd_addr = CHAN_W'(tx_chan + 1'b1);
    rd_bank = ~wsel;
    if (swap_acc) begin
      rd_addr = '0;
      rd_bank = wsel;
    end
  end

  assign rd_data = rd_bank ? rdata1 : rdata0;

  // A channel-0 write coinciding with the swap belongs to the retiring frame but is
  // not yet in the store, so forward it straight into the first beat.
  assign first_data = (in_we && in_addr == '0) ? in_audio : rd_data;

  audio_bank #(.CHAN_W(CHAN_W)) u_bank0 (
    .ck    (ck),
    .rst   (rst),
    .clr   (swap_acc & wsel),
    .we    (in_we & ~wsel),
    .waddr (in_addr),
    .wdata (in_audio),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  audio_bank #(.CHAN_W(CHAN_W)) u_bank1 (
    .ck    (ck),
    .rst   (rst),
    .clr   (swap_acc & ~wsel),
    .we    (in_we & wsel),
    .waddr (in_addr),
    .wdata (in_audio),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      done_d   <= 1'b0;
      wsel     <= 1'b0;
      tx_valid <= 1'b0;
      tx_chan  <= '0;
      tx_data  <= '0;
      tx_last  <= 1'b0;
      overrun  <= 1'b0;
      frames   <= '0;
    end else begin
      done_d <= done;
      case (state)
        ST_IDLE: begin
          if (swap) begin
            wsel     <= ~wsel;
            frames   <= frames + 16'd1;
            state    <= ST_STREAM;
            tx_valid <= 1'b1;
            tx_chan  <= '0;
            tx_data  <= first_data;
            tx_last  <= (LAST_CHAN == '0);
          end
        end
        ST_STREAM: begin
          if (swap) begin
            overrun <= 1'b1;
          end
          if (tx_ready) begin
            if (tx_last) begin
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
              tx_chan  <= '0;
              tx_data  <= '0;
              tx_last  <= 1'b0;
            end else begin
              tx_chan <= rd_addr;
              tx_data <= rd_data;
              tx_last <= (rd_addr == LAST_CHAN);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_OUT_PEAK_EN
  localparam int DEPTH = 2**CHAN_W;

  logic [AUDIO_W-1:0] peak_mem [DEPTH];
  logic [AUDIO_W-1:0] wr_mag;

  assign wr_mag = abs_sat(in_audio);

  // The write update is placed after the clear so a same-channel write overrides it.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        peak_mem[i] <= '0;
      end
      peak <= '0;
    end else begin
      peak <= peak_mem[peak_sel];
      if (peak_clr) begin
        peak_mem[peak_sel] <= '0;
      end
      if (in_we && ((wr_mag > peak_mem[in_addr]) || (peak_clr && peak_sel == in_addr))) begin
        peak_mem[in_addr] <= wr_mag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_out_bank.sv
module tb_audio_out_bank;

  typedef struct packed {
    logic [3:0]  chan;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        ck;
  logic        rst;
  logic        in_we;
  logic [3:0]  in_addr;
  logic [15:0] in_audio;
  logic        done;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_chan;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        overrun;
  logic [15:0] frames;
`ifdef AUDIO_OUT_PEAK_EN
  logic [3:0]  peak_sel;
  logic        peak_clr;
  logic [15:0] peak;
`endif

  int vectors = 0;
  int miscompares = 0;

  beat_t       exp_q[$];
  logic [15:0] fr[8];

  audio_out_bank #(.CHAN_W(4), .OUT_CHANS(8)) dut (
    .ck       (ck),
    .rst      (rst),
    .in_we    (in_we),
    .in_addr  (in_addr),
    .in_audio (in_audio),
    .done     (done),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_chan  (tx_chan),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .overrun  (overrun),
    .frames   (frames)
`ifdef AUDIO_OUT_PEAK_EN
    ,
    .peak_sel (peak_sel),
    .peak_clr (peak_clr),
    .peak     (peak)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every transfer and checks hold-stability under backpressure.
  logic        prev_hold;
  beat_t       prev_beat;
  initial prev_hold = 1'b0;

  always @(negedge ck) begin
    beat_t b;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_beat", {11'd0, tx_chan, tx_data, tx_last}, {11'd0, prev_beat});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_chan", {28'd0, tx_chan}, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_chan", {28'd0, tx_chan}, {28'd0, b.chan});
          chk("beat_data", {16'd0, tx_data}, {16'd0, b.data});
          chk("beat_last", {31'd0, tx_last}, {31'd0, b.last});
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_beat = {tx_chan, tx_data, tx_last};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    in_we    = 1'b1;
    in_addr  = a;
    in_audio = d;
    cyc(1);
    in_we    = 1'b0;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int c = 0; c < 8; c++) begin
      b.chan = 4'(c);
      b.data = fr[c];
      b.last = (c == 7);
      exp_q.push_back(b);
    end
  endtask

  // Rising edge on done held two cycles; the beat must be presented right after the swap edge.
  task automatic pulse_done(input string nm);
    done = 1'b1;
    cyc(1);
    chk({nm, "_first_vld"}, {31'd0, tx_valid}, 32'd1);
    cyc(1);
    done = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      cyc(1);
    end
    chk({nm, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    cyc(2);
  endtask

  initial begin
    rst      = 1'b0;
    in_we    = 1'b0;
    in_addr  = '0;
    in_audio = '0;
    done     = 1'b0;
    tx_ready = 1'b1;
`ifdef AUDIO_OUT_PEAK_EN
    peak_sel = '0;
    peak_clr = 1'b0;
`endif
    #12;
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_frames", {16'd0, frames}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    @(posedge ck);
    #1;
    rst = 1'b1;
    cyc(2);

    // Basic frame: ch c = 0x0100*c.
    for (int c = 0; c < 8; c++) wr(4'(c), 16'(c * 256));
    for (int c = 0; c < 8; c++) fr[c] = 16'(c * 256);
    push_frame();
    pulse_done("basic");
    drain("basic");
    chk("basic_frames", {16'd0, frames}, 1);

    // Sparse: only ch3 written twice, last write wins, others read as zero.
    wr(4'd3, 16'h8001);
    wr(4'd3, 16'h1234);
    for (int c = 0; c < 8; c++) fr[c] = 16'h0000;
    fr[3] = 16'h1234;
    push_frame();
    pulse_done("sparse");
    drain("sparse");
    chk("sparse_frames", {16'd0, frames}, 2);

    // Backpressure: ready pattern 1,0,0,1 per cycle.
    for (int c = 0; c < 8; c++) wr(4'(c), 16'h0A00 + 16'(c));
    for (int c = 0; c < 8; c++) fr[c] = 16'h0A00 + 16'(c);
    push_frame();
    tx_ready = 1'b0;
    pulse_done("bp");
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      cyc(1);
    end
    chk("bp_drain_left", exp_q.size(), 0);
    exp_q.delete();
    tx_ready = 1'b1;
    cyc(2);
    chk("bp_frames", {16'd0, frames}, 3);
    chk("bp_overrun", {31'd0, overrun}, 0);

    // Overrun: frame A stalls, a second done edge is dropped.
    for (int c = 0; c < 8; c++) wr(4'(c), 16'h0C00 + 16'(c));
    for (int c = 0; c < 8; c++) fr[c] = 16'h0C00 + 16'(c);
    push_frame();
    tx_ready = 1'b0;
    pulse_done("ovr_a");
    chk("ovr_a_frames", {16'd0, frames}, 4);
    wr(4'd1, 16'h1111);
    wr(4'd5, 16'h5555);
    cyc(1);
    pulse_done("ovr_drop");
    cyc(1);
    chk("ovr_flag", {31'd0, overrun}, 1);
    chk("ovr_frames_held", {16'd0, frames}, 4);
    wr(4'd6, 16'h6666);
    wr(4'd1, 16'h1112);
    tx_ready = 1'b1;
    drain("ovr_a");
    for (int c = 0; c < 8; c++) fr[c] = 16'h0000;
    fr[1] = 16'h1112;
    fr[5] = 16'h5555;
    fr[6] = 16'h6666;
    push_frame();
    pulse_done("ovr_b");
    drain("ovr_b");
    chk("ovr_b_frames", {16'd0, frames}, 5);
    chk("ovr_sticky", {31'd0, overrun}, 1);

    // Mid-stream asynchronous reset: outputs clear without a clock edge.
    tx_ready = 1'b0;
    pulse_done("midrst");
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, tx_valid}, 0);
    chk("midrst_beat", {11'd0, tx_chan, tx_data, tx_last}, 0);
    chk("midrst_overrun", {31'd0, overrun}, 0);
    chk("midrst_frames", {16'd0, frames}, 0);
    @(posedge ck);
    #1;
    rst = 1'b1;
    tx_ready = 1'b1;
    cyc(3);
    chk("postrst_idle", {31'd0, tx_valid}, 0);

`ifdef AUDIO_OUT_PEAK_EN
    peak_sel = 4'd2;
    wr(4'd2, 16'hFF00);
    wr(4'd2, 16'h0050);
    cyc(1);
    chk("peak_ff00", {16'd0, peak}, 32'h0100);
    wr(4'd2, 16'h8000);
    cyc(1);
    chk("peak_sat", {16'd0, peak}, 32'h7FFF);
    peak_clr = 1'b1;
    cyc(1);
    peak_clr = 1'b0;
    cyc(1);
    chk("peak_clr", {16'd0, peak}, 0);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
